// File: rtl/oled_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : oled_init_seq
// Brief    : Power-up sequencer feeding the SSD1306 init table to the I2C write
//            engine; define OLED_CLEAR_EN to append a full display-clear pass.
// Revision : 1.0 - initial release
// ============================================================================
module oled_init_seq #(
  parameter int         CLK_FREQ     = 8_000_000,
  parameter logic [6:0] SLAVE_ADDR   = 7'h3C,
  parameter int         PWRUP_CYCLES = 800_000,
  parameter int         GAP_CYCLES   = 16,
  parameter int         TO_CYCLES    = 4096,
  parameter int         RETRY_MAX    = 3
) (
  input  logic        I_Clk_in,
  input  logic        I_Rst_n,
  input  logic        I_Go,
  output logic        O_Start,
  output logic [6:0]  O_Slave_Addr,
  output logic        O_R_W_SET,
  output logic [15:0] O_R_W_Data,
  input  logic        I_Done,
  input  logic        I_Error,
  output logic        O_Busy,
  output logic        O_Init_Done,
  output logic        O_Fail,
  output logic [10:0] O_Cmd_Idx
);

  localparam int INIT_LEN = 25;
`ifdef OLED_CLEAR_EN
  localparam int SEQ_LEN = INIT_LEN + 6 + 1024;
`else
  localparam int SEQ_LEN = INIT_LEN;
`endif
  localparam logic [10:0] LAST_IDX = 11'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_CHECK = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic [15:0] data_q, data_d;
  logic [10:0] idx_q, idx_d;

  logic unused_clk_freq;
  assign unused_clk_freq = (CLK_FREQ > 0);

  function automatic logic [15:0] rom_word(input logic [10:0] i);
    logic [7:0] cmd;
    case (i)
      11'd0:  cmd = 8'hAE;  11'd1:  cmd = 8'hD5;  11'd2:  cmd = 8'h80;
      11'd3:  cmd = 8'hA8;  11'd4:  cmd = 8'h3F;  11'd5:  cmd = 8'hD3;
      11'd6:  cmd = 8'h00;  11'd7:  cmd = 8'h40;  11'd8:  cmd = 8'h8D;
      11'd9:  cmd = 8'h14;  11'd10: cmd = 8'h20;  11'd11: cmd = 8'h00;
      11'd12: cmd = 8'hA1;  11'd13: cmd = 8'hC8;  11'd14: cmd = 8'hDA;
      11'd15: cmd = 8'h12;  11'd16: cmd = 8'h81;  11'd17: cmd = 8'hCF;
      11'd18: cmd = 8'hD9;  11'd19: cmd = 8'hF1;  11'd20: cmd = 8'hDB;
      11'd21: cmd = 8'h40;  11'd22: cmd = 8'hA4;  11'd23: cmd = 8'hA6;
      11'd24: cmd = 8'hAF;
`ifdef OLED_CLEAR_EN
      11'd25: cmd = 8'h21;  11'd26: cmd = 8'h00;  11'd27: cmd = 8'h7F;
      11'd28: cmd = 8'h22;  11'd29: cmd = 8'h00;  11'd30: cmd = 8'h07;
`endif
      default: cmd = 8'h00;
    endcase
`ifdef OLED_CLEAR_EN
    // Everything past the addressing commands is a GDDRAM data write of zero.
    if (i > 11'd30) return 16'h4000;
`endif
    return {8'h00, cmd};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == 32'(PWRUP_CYCLES)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_LOAD: begin
        state_d = S_REQ;
        cnt_d   = '0;
      end
      S_REQ: begin
        // A completion on the same cycle as the timeout takes precedence.
        if (I_Done) begin
          err_d   = I_Error;
          state_d = S_CHECK;
        end else if (cnt_q == 32'(TO_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (!err_q) begin
          retry_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 11'd1;
            state_d = S_GAP;
          end
        end else if (retry_q < 8'(RETRY_MAX)) begin
          retry_d = retry_q + 8'd1;
          state_d = S_GAP;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_GAP: begin
        if (cnt_q == 32'(GAP_CYCLES - 1)) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE, S_FAIL: begin
        if (I_Go) begin
          state_d = S_LOAD;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // The word is captured on entry to LOAD so it leads O_Start by a cycle.
    data_d  = (state_d == S_LOAD) ? rom_word(idx_d) : data_q;
    start_d = (state_d == S_REQ);
    busy_d  = (state_d != S_DONE) && (state_d != S_FAIL);
    done_d  = (state_d == S_DONE);
    fail_d  = (state_d == S_FAIL);
  end

  always_ff @(posedge I_Clk_in or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      data_q  <= 16'h0000;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign O_Start      = start_q;
  assign O_Slave_Addr = SLAVE_ADDR;
  assign O_R_W_SET    = 1'b1;
  assign O_R_W_Data   = data_q;
  assign O_Busy       = busy_q;
  assign O_Init_Done  = done_q;
  assign O_Fail       = fail_q;
  assign O_Cmd_Idx    = idx_q;

endmodule
`default_nettype wire
